// File: rtl/switch_io_pkg.sv
// Shared types and constants for the switch input peripheral (switch_io_ctrl).
package switch_io_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        SETTLING = 1'b1
    } sw_state_e;

    localparam logic [1:0]  SW_LEVEL_OFS    = 2'b00;
    localparam logic [1:0]  SW_EDGE_OFS     = 2'b10;

    localparam int unsigned SW_RDATA_W      = 16;
    localparam int unsigned SW_DB_LIMIT_DEF = 1_000_000;
    localparam int unsigned SW_DB_CNT_W_DEF = 20;

endpackage

// File: rtl/switch_io_ctrl_if.sv
// Router-side read bus of the switch peripheral: decode strobe, read strobe, offset, data.
interface switch_io_ctrl_if;
    import switch_io_pkg::*;

    logic                  switch_ctrl;
    logic                  io_read;
    logic [1:0]            addr_low;
    logic [SW_RDATA_W-1:0] io_rdata;

    modport master (output switch_ctrl, output io_read, output addr_low, input  io_rdata);
    modport slave  (input  switch_ctrl, input  io_read, input  addr_low, output io_rdata);

endinterface

// File: rtl/switch_sync.sv
// Plain two-flop synchroniser for asynchronous switch pins.
module switch_sync #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q   <= '0;
            sync_q <= '0;
        end else begin
            s1_q   <= d_i;
            sync_q <= s1_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/switch_io_ctrl.sv
// Synchronises and debounces DIP switches and serves them on the router read bus.
// Define SWITCH_EDGE_CAPTURE_EN to add the sticky rising-edge register at offset 2'b10.
module switch_io_ctrl
    import switch_io_pkg::*;
#(
    parameter int unsigned SW_W     = 16,
    parameter int unsigned DB_LIMIT = SW_DB_LIMIT_DEF,
    parameter int unsigned DB_CNT_W = SW_DB_CNT_W_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [SW_W-1:0] switch_i,
    switch_io_ctrl_if.slave bus
);

    localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DB_LIMIT - 1);

    logic [SW_W-1:0]     sync;
    sw_state_e           state_q, state_d;
    logic [SW_W-1:0]     cand_q, cand_d;
    logic [SW_W-1:0]     deb_q, deb_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;
    logic [SW_W-1:0]     edge_rd;
    logic                read_hit;
    logic [SW_RDATA_W-1:0] rdata_c;

    switch_sync #(.W(SW_W)) u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (switch_i),
        .q_o   (sync)
    );

    // One shared counter: any change of the candidate restarts the whole vector's settle time.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sync != deb_q) begin
                    state_d = SETTLING;
                    cand_d  = sync;
                    cnt_d   = '0;
                end
            end
            SETTLING: begin
                if (sync != cand_q) begin
                    cand_d = sync;
                    cnt_d  = '0;
                end else if (sync == deb_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    deb_d   = cand_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + DB_CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cand_q  <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign read_hit = bus.switch_ctrl & bus.io_read;

`ifdef SWITCH_EDGE_CAPTURE_EN
    logic [SW_W-1:0] edge_q, edge_d, rise;

    // deb_d differs from deb_q only on an accepted update, so this is cand & ~deb at that edge.
    always_comb begin
        rise = deb_d & ~deb_q;
        if (read_hit && (bus.addr_low == SW_EDGE_OFS)) begin
            edge_d = rise;
        end else begin
            edge_d = edge_q | rise;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            edge_q <= '0;
        end else begin
            edge_q <= edge_d;
        end
    end

    assign edge_rd = edge_q;
`else
    assign edge_rd = '0;
`endif

    always_comb begin
        rdata_c = '0;
        if (read_hit) begin
            case (bus.addr_low)
                SW_LEVEL_OFS: rdata_c = SW_RDATA_W'(deb_q);
                SW_EDGE_OFS:  rdata_c = SW_RDATA_W'(edge_rd);
                default:      rdata_c = '0;
            endcase
        end
    end

    assign bus.io_rdata = rdata_c;

endmodule

// File: tb/tb_switch_io_ctrl.sv
// Directed and randomized checks of switch_io_ctrl against a run-length debounce model.
module tb_switch_io_ctrl;

    localparam int unsigned DBL = 4;
`ifdef SWITCH_EDGE_CAPTURE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] sw;
    int          n_cmp = 0;
    int          n_bad = 0;

    switch_io_ctrl_if bus();

    switch_io_ctrl #(.SW_W(16), .DB_LIMIT(DBL), .DB_CNT_W(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .switch_i (sw),
        .bus      (bus)
    );

    always #5 clock = ~clock;

    // Model: a value is accepted once the pins (seen two edges late) held it for DB_LIMIT+1 edges.
    logic [15:0] m_deb, m_edge, m_last;
    int          m_run;
    logic [15:0] m_hist[$];

    task automatic m_reset();
        m_deb  = '0;
        m_edge = '0;
        m_last = '0;
        m_run  = 0;
        m_hist = {16'h0000, 16'h0000};
    endtask

    task automatic m_step();
        logic [15:0] v;
        logic [15:0] rise;
        bit          clr;
        clr = bus.switch_ctrl && bus.io_read && (bus.addr_low == 2'b10);
        m_hist.push_back(sw);
        v = m_hist.pop_front();
        if (v == m_last) m_run++;
        else m_run = 1;
        m_last = v;
        rise = '0;
        if (m_run >= int'(DBL) + 1 && v != m_deb) begin
            rise  = v & ~m_deb;
            m_deb = v;
        end
        m_edge = clr ? rise : (m_edge | rise);
    endtask

    function automatic logic [15:0] m_read();
        if (!(bus.switch_ctrl && bus.io_read)) return 16'h0000;
        if (bus.addr_low == 2'b00) return m_deb;
        if (bus.addr_low == 2'b10 && EDGE_EN) return m_edge;
        return 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [15:0] exp);
        n_cmp++;
        assert (bus.io_rdata === exp)
        else begin
            n_bad++;
            $error("FAIL %s: io_rdata=%h expected=%h", tag, bus.io_rdata, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) m_step();
        #1;
    endtask

    task automatic rd(input bit c, input bit r, input logic [1:0] a);
        bus.switch_ctrl = c;
        bus.io_read     = r;
        bus.addr_low    = a;
    endtask

    logic [15:0] pool [4] = '{16'h0000, 16'h00A5, 16'hFFFF, 16'h1234};

    initial begin
        // Reset with all pins high
        sw    = 16'hFFFF;
        reset = 1'b0;
        rd(1, 1, 2'b00);
        m_reset();
        repeat (2) tick();
        chk("t1_reset", 16'h0000);

        // Held change appears on the 7th edge after release
        reset = 1'b1;
        sw    = 16'h00A5;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk($sformatf("t2_edge%0d", e), (e < 7) ? 16'h0000 : 16'h00A5);
            chk("t2_model", m_read());
        end

        // Two-cycle glitch is rejected
        sw = 16'h00A4;
        repeat (2) tick();
        sw = 16'h00A5;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t3_glitch", 16'h00A5);
        end

        // Read gating
        rd(1, 0, 2'b00); #1;
        chk("t4_no_read", 16'h0000);
        rd(0, 1, 2'b00); #1;
        chk("t4_no_ctrl", 16'h0000);
        rd(1, 1, 2'b01); #1;
        chk("t4_bad_ofs", 16'h0000);

        // Edge register: capture, clear on read, new rising bits only
        rd(1, 1, 2'b00);
        sw = 16'h0000;
        repeat (8) tick();
        rd(1, 1, 2'b10);
        tick();
        rd(1, 1, 2'b00);
        sw = 16'h00A5;
        repeat (8) tick();
        rd(1, 1, 2'b10); #1;
        chk("t5_edge_a5", EDGE_EN ? 16'h00A5 : 16'h0000);
        tick();
        chk("t5_edge_clr", 16'h0000);
        rd(1, 1, 2'b00);
        sw = 16'h00FF;
        repeat (8) tick();
        rd(1, 1, 2'b10); #1;
        chk("t5_edge_5a", EDGE_EN ? 16'h005A : 16'h0000);
        chk("t5_model", m_read());

        // Clear and new rising event on the same edge: the event survives
        tick();
        rd(1, 1, 2'b00);
        sw = 16'h0000;
        repeat (8) tick();
        rd(1, 1, 2'b10);
        tick();
        rd(1, 1, 2'b00);
        sw = 16'h0F00;
        repeat (6) tick();
        rd(1, 1, 2'b10); #1;
        chk("t7_pre", m_read());
        tick();
        chk("t7_new_wins", EDGE_EN ? 16'h0F00 : 16'h0000);
        tick();
        chk("t7_cleared", 16'h0000);

        // Reset mid-settling, then full latency after release
        rd(1, 1, 2'b00);
        sw = 16'h0000;
        repeat (8) tick();
        chk("t6_base", 16'h0000);
        sw = 16'h0F0F;
        repeat (5) tick();
        reset = 1'b0;
        m_reset();
        #1;
        chk("t6_rst_now", 16'h0000);
        tick();
        reset = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk($sformatf("t6_edge%0d", e), (e < 7) ? 16'h0000 : 16'h0F0F);
        end

        // Randomized traffic with occasional glitches and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) sw = pool[$urandom_range(0, 3)];
            rd(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
               2'($urandom_range(0, 3)));
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                m_reset();
                #1;
                chk("rnd_reset", m_read());
                tick();
                reset = 1'b1;
            end
            tick();
            chk("rnd", m_read());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
